// File: rtl/home_arb_pkg.sv
// ---------------------------------------------------------------------------
// home_arb_pkg
// Shared types and helpers for the home power arbiter.
//   slot_state_t     per-requester slot state
//   cnt_w(n)         width needed to hold the values 0..n
//   DEFAULT_COOLDOWN default hold-off after a grant is released
//   DEFAULT_RUN_LIMIT default RUN bound (only used with HOME_ARB_TIMEOUT_EN)
// ---------------------------------------------------------------------------
package home_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        COOL = 2'd2
    } slot_state_t;

    localparam int DEFAULT_COOLDOWN  = 2;
    localparam int DEFAULT_RUN_LIMIT = 16;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/home_arb_if.sv
// ---------------------------------------------------------------------------
// home_arb_if
// Bundle between the appliance controllers (master) and the arbiter (slave).
//   auth_ok        1 = user authorized, new grants allowed
//   alarm          1 = safety alarm, shed all loads
//   req[N_REQ]     level request per requester
//   done[N_REQ]    1-cycle pulse: requester finished
//   grant[N_REQ]   registered grant per requester
//   active_count   number of grant bits set
//   busy           active_count == MAX_ACTIVE
//   timeout_pulse  1-cycle pulse on forced release
// ---------------------------------------------------------------------------
interface home_arb_if
    import home_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int MAX_ACTIVE = 2
);
    localparam int CNT_W = cnt_w(MAX_ACTIVE);

    logic             auth_ok;
    logic             alarm;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] done;
    logic [N_REQ-1:0] grant;
    logic [CNT_W-1:0] active_count;
    logic             busy;
    logic [N_REQ-1:0] timeout_pulse;

    modport master (
        output auth_ok, alarm, req, done,
        input  grant, active_count, busy, timeout_pulse
    );

    modport slave (
        input  auth_ok, alarm, req, done,
        output grant, active_count, busy, timeout_pulse
    );

endinterface

// File: rtl/home_arb_slot.sv
// ---------------------------------------------------------------------------
// home_arb_slot
// One requester's slot: IDLE -> RUN -> COOL -> IDLE.
// Optional RUN bound enabled by the macro HOME_ARB_TIMEOUT_EN.
//   clk, reset     clock, async active-low reset
//   grant_en       top-level pick for this slot (already gated by auth/alarm/count)
//   req, done      requester level request / finish pulse
//   alarm          shed: RUN goes to COOL on the next edge
//   grant          registered, 1 exactly while in RUN
//   grant_nxt      grant value after the coming edge (feeds the count register)
//   idle           slot is in IDLE
//   timeout_pulse  1-cycle pulse aligned with grant falling on a forced release
//
// state | meaning
// IDLE  | waiting for a pick
// RUN   | granted, load powered
// COOL  | hold-off for COOLDOWN cycles, req ignored
// ---------------------------------------------------------------------------
module home_arb_slot
    import home_arb_pkg::*;
#(
    parameter int COOLDOWN  = DEFAULT_COOLDOWN,
    parameter int RUN_LIMIT = DEFAULT_RUN_LIMIT
) (
    input  logic clk,
    input  logic reset,
    input  logic grant_en,
    input  logic req,
    input  logic done,
    input  logic alarm,
    output logic grant,
    output logic grant_nxt,
    output logic idle,
    output logic timeout_pulse
);
    localparam int CW = cnt_w(COOLDOWN);

    slot_state_t   state_q, state_d;
    logic [CW-1:0] cool_q, cool_d;
    logic          run_expired;

`ifdef HOME_ARB_TIMEOUT_EN
    localparam int RW = cnt_w(RUN_LIMIT);
    logic [RW-1:0] run_q;
    logic          tp_q;

    // Reloaded outside RUN, so the k-th RUN cycle sees RUN_LIMIT-k.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q <= RW'(RUN_LIMIT - 1);
            tp_q  <= 1'b0;
        end else begin
            if (state_q != RUN)
                run_q <= RW'(RUN_LIMIT - 1);
            else if (run_q != '0)
                run_q <= run_q - 1'b1;
            // Any ordinary release in the same cycle suppresses the pulse.
            tp_q <= (state_q == RUN) && run_expired && !alarm && !done && req;
        end
    end

    assign run_expired   = (run_q == '0);
    assign timeout_pulse = tp_q;
`else
    assign run_expired   = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cool_q  <= '0;
        end else begin
            state_q <= state_d;
            cool_q  <= cool_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cool_d  = cool_q;
        case (state_q)
            IDLE: begin
                if (grant_en)
                    state_d = RUN;
            end
            RUN: begin
                if (alarm || done || !req || run_expired) begin
                    state_d = COOL;
                    cool_d  = CW'(COOLDOWN - 1);
                end
            end
            COOL: begin
                if (cool_q == '0)
                    state_d = IDLE;
                else
                    cool_d = cool_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant     = (state_q == RUN);
    assign grant_nxt = (state_d == RUN);
    assign idle      = (state_q == IDLE);

endmodule

// File: rtl/home_power_arbiter.sv
// ---------------------------------------------------------------------------
// home_power_arbiter
// Grants up to MAX_ACTIVE concurrent power slots to N_REQ appliances
// (washer, dishwasher, heater, cooler) with round-robin fairness and a
// cooldown after each release. Optional RUN bound: HOME_ARB_TIMEOUT_EN.
//   clk     system clock, rising edge
//   reset   asynchronous active-low reset
//   bus     home_arb_if.slave: auth_ok, alarm, req, done in;
//           grant, active_count, busy, timeout_pulse out
// ---------------------------------------------------------------------------
module home_power_arbiter
    import home_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int MAX_ACTIVE = 2,
    parameter int COOLDOWN   = DEFAULT_COOLDOWN,
    parameter int RUN_LIMIT  = DEFAULT_RUN_LIMIT
) (
    input logic        clk,
    input logic        reset,
    home_arb_if.slave  bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = cnt_w(MAX_ACTIVE);

    logic [PTR_W-1:0] rr_ptr, pick;
    logic [CNT_W-1:0] active_q, count_nxt;
    logic             busy_q, found, can_grant;
    logic [N_REQ-1:0] idle, eligible, grant_en, grant_vec, grant_nxt, tp_vec;
    int               idx;

    // Uses the registered count: a slot freed this cycle is reusable next cycle.
    assign can_grant = bus.auth_ok && !bus.alarm && (int'(active_q) < MAX_ACTIVE);
    assign eligible  = bus.req & idle;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        grant_en = '0;
        if (found && can_grant)
            grant_en[pick] = 1'b1;
    end

    always_comb begin
        count_nxt = '0;
        for (int i = 0; i < N_REQ; i++)
            count_nxt = count_nxt + CNT_W'(grant_nxt[i]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr   <= '0;
            active_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            if (found && can_grant)
                rr_ptr <= PTR_W'((int'(pick) + 1) % N_REQ);
            active_q <= count_nxt;
            busy_q   <= (int'(count_nxt) == MAX_ACTIVE);
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_slot
        home_arb_slot #(
            .COOLDOWN  (COOLDOWN),
            .RUN_LIMIT (RUN_LIMIT)
        ) u_slot (
            .clk           (clk),
            .reset         (reset),
            .grant_en      (grant_en[g]),
            .req           (bus.req[g]),
            .done          (bus.done[g]),
            .alarm         (bus.alarm),
            .grant         (grant_vec[g]),
            .grant_nxt     (grant_nxt[g]),
            .idle          (idle[g]),
            .timeout_pulse (tp_vec[g])
        );
    end

    assign bus.grant         = grant_vec;
    assign bus.active_count  = active_q;
    assign bus.busy          = busy_q;
    assign bus.timeout_pulse = tp_vec;

endmodule
